// File: rtl/crc16_pkg.sv
// crc16_pkg
// Shared CRC-16 definitions for the byte-parallel generator and checker.
//   crc16_next(c, d) : one-byte CRC update (the single CRC definition)
//   CRC_INIT         : CRC start value at the beginning of every frame
//   win_state_e      : fill level of the checker's two-byte delay window
package crc16_pkg;

    localparam logic [15:0] CRC_INIT = 16'h0000;

    typedef enum logic [1:0] {
        WIN_EMPTY = 2'd0,
        WIN_ONE   = 2'd1,
        WIN_FULL  = 2'd2
    } win_state_e;

    // Byte-parallel update. The data byte is folded in with bit 7 paired
    // against CRC bit 8, so it is not a plain table-driven MSB-first form;
    // keep it exactly as written so generator and checker stay in lock-step.
    function automatic logic [15:0] crc16_next(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] n;
        n[0]  = (^d) ^ (^c[15:8]);
        n[1]  = (^d[6:0]) ^ (^c[15:9]);
        n[2]  = d[7] ^ d[6] ^ c[9] ^ c[8];
        for (int i = 3; i <= 7; i++) begin
            n[i] = d[9-i] ^ d[8-i] ^ c[i+7] ^ c[i+6];
        end
        n[8]  = d[1] ^ d[0] ^ c[15] ^ c[14] ^ c[0];
        n[9]  = d[0] ^ c[15] ^ c[1];
        n[14:10] = c[6:2];
        n[15] = (^d) ^ (^c[15:7]);
        return n;
    endfunction

endpackage

// File: rtl/crc16_checker.sv
// crc16_checker
// Receive-side CRC-16 checker. A frame is payload bytes followed by the
// two CRC bytes (high byte first). The last two accepted bytes are held in
// a delay window so the trailer is never forwarded; payload bytes leave the
// window (and enter the CRC) as newer bytes push them out.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/in_data : incoming frame byte
//   in_last          : final byte of the frame (CRC[7:0])
//   out_valid/out_data : forwarded payload byte (registered)
//   done             : one-cycle frame-result pulse
//   crc_ok           : with done, received CRC matches computed CRC
//   short_err        : with done, frame had fewer than 3 bytes
module crc16_checker
    import crc16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       done,
    output logic       crc_ok,
    output logic       short_err
);

    win_state_e  state_q, state_d;
    logic [7:0]  w_old_q, w_old_d;
    logic [7:0]  w_new_q, w_new_d;
    logic [15:0] crc_q, crc_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        done_q, done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        short_err_q, short_err_d;

    // CRC including the byte leaving the window this cycle.
    logic [15:0] crc_upd;
    assign crc_upd = crc16_next(crc_q, w_old_q);

    always_comb begin
        state_d     = state_q;
        w_old_d     = w_old_q;
        w_new_d     = w_new_q;
        crc_d       = crc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        crc_ok_d    = 1'b0;
        short_err_d = 1'b0;

        if (in_valid) begin
            // The window always shifts; in EMPTY/ONE the stale w_old is
            // simply never used.
            w_old_d = w_new_q;
            w_new_d = in_data;

            if (in_last) begin
                crc_d   = CRC_INIT;
                state_d = WIN_EMPTY;
                done_d  = 1'b1;
                if (state_q == WIN_FULL) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w_old_q;
                    crc_ok_d    = ({w_new_q, in_data} == crc_upd);
                end else begin
                    short_err_d = 1'b1;
                end
            end else begin
                unique case (state_q)
                    WIN_EMPTY: state_d = WIN_ONE;
                    WIN_ONE:   state_d = WIN_FULL;
                    WIN_FULL: begin
                        crc_d       = crc_upd;
                        out_valid_d = 1'b1;
                        out_data_d  = w_old_q;
                    end
                    default:   state_d = WIN_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WIN_EMPTY;
            w_old_q     <= 8'h00;
            w_new_q     <= 8'h00;
            crc_q       <= CRC_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_old_q     <= w_old_d;
            w_new_q     <= w_new_d;
            crc_q       <= crc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            short_err_q <= short_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign crc_ok    = crc_ok_q;
    assign short_err = short_err_q;

endmodule

// File: tb/tb_crc16_checker.sv
// tb_crc16_checker
// Drives directed and random frames into crc16_checker and checks every
// output each cycle against a frame-level model: payload forwarded with a
// two-byte lag, and a bit-serial CRC (poly 0x8005, data bits LSB first).
module tb_crc16_checker;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic [7:0] out_data;
    logic       done;
    logic       crc_ok;
    logic       short_err;

    int n_chk  = 0;
    int n_fail = 0;

    crc16_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done),
        .crc_ok    (crc_ok),
        .short_err (short_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial LFSR, each data byte shifted in LSB first.
    function automatic logic [15:0] ref_crc(input bq_t b);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic expect_outs(input string tag, input logic ov,
                               input logic [7:0] od, input logic dn,
                               input logic ok, input logic sh);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        if (ov) check({tag, ".out_data"}, 32'(out_data), 32'(od));
        check({tag, ".done"},      32'(done),      32'(dn));
        check({tag, ".crc_ok"},    32'(crc_ok),    32'(ok));
        check({tag, ".short_err"}, 32'(short_err), 32'(sh));
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int g = 0; g < n; g++) begin
            @(posedge clk); #1;
            expect_outs({tag, ".idle"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Sends a whole frame (or only its first abort_after bytes, then a
    // reset) and checks the outputs after every accepted byte and gap.
    task automatic send_frame(input string tag, input bq_t f, input int gap,
                              input int abort_after);
        int   n;
        bq_t  pay;
        logic ok;
        n = f.size();
        pay = {};
        for (int i = 0; i + 2 < n; i++) pay.push_back(f[i]);
        ok = (n >= 3) && ({f[n-2], f[n-1]} == ref_crc(pay));
        for (int p = 0; p < n; p++) begin
            if (p == abort_after) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                expect_outs({tag, ".rst"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
                check({tag, ".rst.out_data"}, 32'(out_data), 32'h0);
                idle_cycles(tag, 1);
                return;
            end
            in_valid = 1'b1;
            in_data  = f[p];
            in_last  = (p == n - 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'h00;
            if (p == n - 1) begin
                if (n >= 3) expect_outs(tag, 1'b1, f[n-3], 1'b1, ok, 1'b0);
                else        expect_outs(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            end else begin
                expect_outs(tag, (p >= 2), (p >= 2) ? f[(p >= 2) ? p-2 : 0] : 8'h00,
                            1'b0, 1'b0, 1'b0);
            end
            if (gap > 0) idle_cycles(tag, gap);
        end
    endtask

    initial begin
        bq_t f;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        idle_cycles("post_reset", 2);

        f = '{8'h01, 8'h83, 8'h03};
        send_frame("f3_good", f, 0, -1);
        idle_cycles("gap", 1);

        f = '{8'h01, 8'h00, 8'h80, 8'h09};
        send_frame("f4_gaps", f, 2, -1);

        f = '{8'h01, 8'h83, 8'h02};
        send_frame("f3_bad", f, 0, -1);
        idle_cycles("gap", 1);

        f = '{8'h00, 8'h00};
        send_frame("short2", f, 0, -1);
        f = '{8'h55};
        send_frame("short1", f, 1, -1);

        // back-to-back, second frame must restart from CRC 0
        f = '{8'h01, 8'h83, 8'h03};
        send_frame("b2b_a", f, 0, -1);
        f = '{8'h00, 8'h00, 8'h00};
        send_frame("b2b_b", f, 0, -1);
        idle_cycles("gap", 1);

        f = '{8'h01, 8'h00, 8'h80, 8'h09};
        send_frame("abort", f, 0, 2);
        send_frame("resend", f, 0, -1);

        for (int r = 0; r < 60; r++) begin
            bq_t         pay;
            logic [15:0] c;
            int          plen;
            pay = {};
            if ($urandom_range(0, 7) == 0) begin
                plen = $urandom_range(1, 2);
                for (int i = 0; i < plen; i++) pay.push_back(8'($urandom));
                f = pay;
            end else begin
                plen = $urandom_range(1, 8);
                for (int i = 0; i < plen; i++) pay.push_back(8'($urandom));
                c = ref_crc(pay);
                f = pay;
                f.push_back(c[15:8]);
                f.push_back(c[7:0]);
                if ($urandom_range(0, 3) == 0) begin
                    int idx;
                    idx = $urandom_range(0, f.size() - 1);
                    f[idx] = f[idx] ^ (8'h01 << $urandom_range(0, 7));
                end
            end
            send_frame("rand", f, $urandom_range(0, 2), -1);
        end

        idle_cycles("tail", 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crc16_checker.md
# crc16_checker

Byte-stream CRC-16 checker: the receive-side counterpart of the team's byte-parallel CRC-16 generator. It accepts a frame of payload bytes followed by the two CRC bytes the generator appends (high byte first). It forwards the payload with a fixed delay, recomputes the CRC over the payload only, and reports pass/fail once per frame. It sits between the byte deserializer and the frame consumer; there is no backpressure path.

## Interface
- No parameters; byte width 8 and CRC width 16 are fixed.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is a valid frame byte this cycle.
- in_data  in  8  frame byte: payload bytes first, then CRC[15:8], then CRC[7:0].
- in_last  in  1  qualified by in_valid; marks the final byte of the frame, which is CRC[7:0].
- out_valid  out  1  out_data holds a payload byte (registered).
- out_data  out  8  forwarded payload byte.
- done  out  1  one-cycle pulse: frame result is valid.
- crc_ok  out  1  qualified by done; received CRC equals computed CRC.
- short_err  out  1  qualified by done; frame was shorter than 3 bytes.

## Operation
- Byte update function crc16_next(c, d) gives n[15:0]. It is identical to the generator's update and is the sole CRC definition:
  - n0 = ^d ^ ^c[15:8]
  - n1 = ^d[6:0] ^ ^c[15:9]
  - n2 = d7^d6^c9^c8
  - n[i] = d[9-i]^d[8-i]^c[i+7]^c[i+6] for i = 3..7
  - n8 = d1^d0^c15^c14^c0
  - n9 = d0^c15^c1
  - n[14:10] = c[6:2]
  - n15 = ^d ^ ^c[15:7]
  - Initial value 0x0000; no final XOR.
- Two-byte delay window (w_old, w_new) hides the trailer. The window FSM has three states: EMPTY, ONE, FULL (number of bytes buffered).
- Accepted byte, not last:
  - EMPTY -> ONE.
  - ONE -> FULL.
  - FULL: crc <= crc16_next(crc, w_old); emit w_old on out; shift the window.
- Accepted byte with in_last while in FULL:
  - crc_final = crc16_next(crc, w_old); emit w_old.
  - crc_ok = ({w_new, in_data} == crc_final).
  - Pulse done; crc <= 0; state -> EMPTY.
- Accepted byte with in_last while in EMPTY or ONE (frame of 1 or 2 bytes):
  - done=1, crc_ok=0, short_err=1; nothing emitted; crc <= 0; state -> EMPTY.
- in_valid=0: all state holds; gaps are allowed anywhere in a frame.
- Trailer bytes never appear on out_data.

## Timing
- Reset values: out_valid=0, out_data=0x00, done=0, crc_ok=0, short_err=0, crc=0x0000, state EMPTY, window 0x00.
- Reset mid-frame discards the partial frame with no done pulse.
- Payload byte b[k] appears on out one cycle after b[k+2] is accepted.
- done asserts one cycle after in_last is accepted, in the same cycle as the last payload byte on out. crc_ok and short_err are 0 whenever done=0.
- Back-to-back frames: the byte after in_last starts a new frame in EMPTY with no idle cycle.
- Throughput: one byte per cycle sustained.

## Structure
- crc16_pkg: crc16_next function, CRC_INIT = 16'h0000, and the window-state enum. The package is shared with the generator, which is to be refactored onto crc16_next.
- No sub-modules: a single FSM plus datapath in crc16_checker.

## Test plan
- Frame {0x01, 0x83, 0x03} -> out 0x01 once; done with crc_ok=1, short_err=0.
- Frame {0x01, 0x00, 0x80, 0x09}, 2-cycle gap between each byte -> out 0x01 then 0x00; done with crc_ok=1.
- Frame {0x01, 0x83, 0x02} (corrupted trailer) -> out 0x01; done with crc_ok=0, short_err=0.
- Frames {0x00, 0x00} and {0x55} -> no out; done with short_err=1, crc_ok=0.
- Back-to-back {0x01, 0x83, 0x03} then {0x00, 0x00, 0x00} with no idle -> two done pulses, both crc_ok=1; second frame's CRC starts from 0x0000.
- rst asserted after 0x01, 0x00 of the 4-byte frame, then the full frame resent -> no done for the aborted frame; the resent frame passes.
